// File: rtl/tdm_demux7.sv
// Seven-slot TDM demultiplexer: routes framed serial beats to o0..o6 and commits the whole frame at once.
// Optional even-parity beat on slot 7 when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux7 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] din,
    output logic [2:0]       slot,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic             frame_valid,
    output logic             frame_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [2:0] LAST = 3'd7;
`else
    localparam logic [2:0] LAST = 3'd6;
`endif

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] shadow [0:6];

    assign slot = cnt;

`ifdef TDM_DEMUX_PARITY_EN
    logic par;
    logic par_ok;

    always_comb begin
        par = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            par = par ^ (^shadow[i]);
        end
        par_ok = (par == din[0]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            o0          <= '0;
            o1          <= '0;
            o2          <= '0;
            o3          <= '0;
            o4          <= '0;
            o5          <= '0;
            o6          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    // A SOF inside RECV aborts the partial frame but still starts the new one.
                    if (state == RECV) begin
                        frame_err <= 1'b1;
                    end
                    shadow[0] <= din;
                    cnt       <= 3'd1;
                    state     <= RECV;
                end else if (state == IDLE) begin
                    frame_err <= 1'b1;
                end else if (cnt == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                    if (par_ok) begin
                        o0          <= shadow[0];
                        o1          <= shadow[1];
                        o2          <= shadow[2];
                        o3          <= shadow[3];
                        o4          <= shadow[4];
                        o5          <= shadow[5];
                        o6          <= shadow[6];
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
`else
                    o0          <= shadow[0];
                    o1          <= shadow[1];
                    o2          <= shadow[2];
                    o3          <= shadow[3];
                    o4          <= shadow[4];
                    o5          <= shadow[5];
                    o6          <= din;
                    frame_valid <= 1'b1;
`endif
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    for (int unsigned i = 1; i < 7; i++) begin
                        if (cnt == 3'(i)) begin
                            shadow[i] <= din;
                        end
                    end
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/tdm_demux7.md
# tdm_demux7

Seven-slot time-division demultiplexer: the receive end of the 7:1 channel-select mux path. A serial stream of framed beats arrives, beat 0 marked by a start-of-frame flag. Each beat is routed to one of seven output channels, and the completed frame is committed to all outputs at once. It sits after the serialising 7:1 mux/link and restores the seven parallel channels.

## Interface

Parameters:
- `WIDTH`, default 1: bits per channel/beat.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  beat present on `din` this cycle.
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks slot 0.
- `din`  in  `WIDTH`  beat data.
- `slot`  out  3  slot index expected on the next beat; 0 in IDLE. Mirrors the `s2,s1,s0` select of the sending mux.
- `o0`..`o6`  out  `WIDTH` each  registered channel outputs.
- `frame_valid`  out  1  one-cycle pulse; `o0`..`o6` were just updated.
- `frame_err`  out  1  one-cycle pulse; a framing or parity error occurred.

## Operation

- FSM has two states, IDLE and RECV. It holds a 3-bit slot counter `cnt` and a shadow register per slot.
- **Reset** (async, `rst_n`=0): state IDLE; `cnt`=0; all shadow regs, `o0`..`o6`, `slot`, `frame_valid` and `frame_err` = 0.
- **`in_valid`=0**: no state change. Gaps of any length are allowed mid-frame.
- **IDLE**
  - `in_valid` with `in_sof`: shadow[0]←`din`; `cnt`←1; go to RECV.
  - `in_valid` without `in_sof`: beat dropped; `frame_err` pulses; stay in IDLE.
- **RECV**
  - `in_valid` without `in_sof`: shadow[`cnt`]←`din`.
  - On the last slot (`cnt`=6): `o0`..`o6` ← shadow[0..5] plus the current `din`, all in the same edge. `frame_valid` pulses, `cnt`←0, go to IDLE.
  - Otherwise `cnt`←`cnt`+1.
- **Early `in_sof` in RECV** (`cnt`≠0): `frame_err` pulses. The partial frame is discarded and outputs are untouched. The current beat restarts the frame as slot 0 (`cnt`←1), so it is never lost.
- Outputs change only on commit. A partial frame never reaches `o0`..`o6`.
- `slot` = `cnt` at all times.

## Timing

- The beat's sample edge is the edge where `in_valid`=1.
- Latency is 1 cycle: with the final beat sampled at edge N, `o0`..`o6` and `frame_valid` are visible after edge N, for the cycle N..N+1.
- `frame_valid` and `frame_err` are high for exactly one cycle per event. Both are never high together, except a parity failure, which raises `frame_err` only.
- Back-to-back frames are supported: `in_sof` may arrive on the cycle immediately after the last beat, giving a sustained throughput of 1 frame per 7 beats.
- Reset asserted mid-frame clears everything immediately. After deassertion, the first beat without `in_sof` raises `frame_err`.

## Configuration

- Macro: `TDM_DEMUX_PARITY_EN`.
- **Defined**: the frame is 8 beats.
  - Slot 7 carries even parity: the XOR of all bits of slots 0..6 equals `din` at slot 7. `cnt` runs 0..7 and `slot` reads 7 during the parity beat.
  - Parity match: commit and `frame_valid` on the slot-7 beat.
  - Parity mismatch: no commit, outputs hold, `frame_err` pulses, return to IDLE.
- **Undefined**: 7-beat frame exactly as in Operation; no parity logic.

## Test plan

- **Basic frame**: `WIDTH`=1, beats 1,0,1,1,0,0,1 with `in_sof` on the first, contiguous → after the 7th edge, `o0`..`o6`=1,0,1,1,0,0,1 and `frame_valid` high one cycle. `slot` steps 0→1…6→0.
- **Gaps**: same frame with 3 idle cycles between slots 2 and 3 → identical outputs. `frame_valid` follows the 7th beat by 1 cycle. `slot` holds 3 during the gap.
- **Early SOF**: 4 beats, then a new `in_sof` frame of all-1s → `frame_err` on the restart beat, outputs keep their previous values, then all-1s commit with `frame_valid`.
- **Stray beat in IDLE**: `in_valid`=1, `in_sof`=0 after reset → `frame_err` pulse, `slot`=0, outputs all 0.
- **Reset mid-frame**: assert `rst_n`=0 after slot 3 → all outputs and `slot` are 0 asynchronously. A fresh frame afterwards commits correctly.
- **Parity** (`TDM_DEMUX_PARITY_EN` defined): frame 1,0,1,1,0,0,1 plus parity 0 → commit. The same frame with parity 1 → `frame_err`, outputs unchanged, no `frame_valid`.
